// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// BIT_SERIALIZER_PARITY_EN appends one even-parity bit to each frame.
package bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_e;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Number of sout_valid cycles produced for each accepted word.
  function automatic int unsigned frame_len(int unsigned width, bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a valid/ready input and gap-free back-to-back frames.
// Optional macro BIT_SERIALIZER_PARITY_EN adds a trailing even-parity bit per frame.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             handshake;
  logic             final_bit;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_shreg;
  logic [WIDTH-1:0] shifted;

  // The shift register holds the bits still to be sent, next one at the output end.
  assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign load_shreg = MSB_FIRST ? (din << 1) : (din >> 1);
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted    = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

  assign din_ready  = (state_q == IDLE) || final_bit;
  assign handshake  = din_valid && din_ready;
  assign sout       = sout_q;
  assign sout_valid = (state_q != IDLE);
  assign sout_last  = final_bit;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      SHIFT: begin
        if (cnt_q != '0) begin
          sout_d  = next_bit;
          shreg_d = shifted;
          cnt_d   = cnt_q - 1'b1;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
          sout_d  = parity_q;
`else
          state_d = IDLE;
          sout_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = 1'b0;
      end
    endcase

    // A handshake only happens in IDLE or on the final bit, so it overrides the exit.
    if (handshake) begin
      state_d  = SHIFT;
      shreg_d  = load_shreg;
      cnt_d    = CNT_LOAD;
      sout_d   = first_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d = ^din;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
